// File: rtl/hazard_unit.sv
// 5-stage MIPS hazard unit: forwarding, load-use/branch stalls, memory-wait FSM.
// Optional HAZARD_STATS_EN adds saturating stall/flush/memwait counters.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int STAT_W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          rsd,
    input  logic [4:0]          rtd,
    input  logic [4:0]          rse,
    input  logic [4:0]          rte,
    input  logic [4:0]          writerege,
    input  logic [4:0]          writeregm,
    input  logic [4:0]          writeregw,
    input  logic                branchd,
    input  logic                regwritee,
    input  logic                memtorege,
    input  logic                regwritem,
    input  logic                memtoregm,
    input  logic                memwritem,
    input  logic                regwritew,
    input  logic                dmem_ack,
    output logic                dmem_req,
    output logic                forwardad,
    output logic                forwardbd,
    output logic [1:0]          forwardae,
    output logic [1:0]          forwardbe,
    output logic                stallf,
    output logic                stalld,
    output logic                stalle,
    output logic                stallm,
    output logic                stallw,
    output logic                flushe,
`ifdef HAZARD_STATS_EN
    output logic [STAT_W-1:0]   stall_cycles,
    output logic [STAT_W-1:0]   flush_count,
    output logic [STAT_W-1:0]   memwait_cycles,
`endif
    output logic                mem_err
);

    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || STAT_W < 1) begin : g_bad_cfg
        $error("hazard_unit: bad MEM_TIMEOUT or STAT_W");
    end

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_err;
    logic          w_err_nxt;

    logic w_lwstall;
    logic w_brstall;
    logic w_memop;
    logic w_timeout_hit;
    logic w_memstall;
    logic w_frontstall;

    // Register 0 is hardwired, so it never takes a forwarded value.
    function automatic logic [1:0] fwd_e(input logic [4:0] rs,
                                         input logic [4:0] wm,
                                         input logic       rwm,
                                         input logic [4:0] ww,
                                         input logic       rww);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0 && rs == wm && rwm) begin
            sel = 2'b10;
        end else if (rs != 5'd0 && rs == ww && rww) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        forwardae = fwd_e(rse, writeregm, regwritem, writeregw, regwritew);
        forwardbe = fwd_e(rte, writeregm, regwritem, writeregw, regwritew);
        forwardad = (rsd != 5'd0) && (rsd == writeregm) && regwritem;
        forwardbd = (rtd != 5'd0) && (rtd == writeregm) && regwritem;
    end

    always_comb begin
        w_lwstall = memtorege && (rte == rsd || rte == rtd);
        w_brstall = branchd &&
                    ((regwritee && (writerege == rsd || writerege == rtd)) ||
                     (memtoregm && (writeregm == rsd || writeregm == rtd)));
        w_memop   = memtoregm || memwritem;
        w_timeout_hit = (r_state == S_WAIT) && (r_cnt == LAST);
        w_memstall    = w_memop && !dmem_ack && !w_timeout_hit;
        w_frontstall  = w_lwstall || w_brstall || w_memstall;
    end

    // A frozen pipeline keeps E intact; the bubble is inserted once it thaws.
    always_comb begin
        dmem_req = w_memop;
        stallf   = w_frontstall;
        stalld   = w_frontstall;
        stalle   = w_memstall;
        stallm   = w_memstall;
        stallw   = w_memstall;
        flushe   = (w_lwstall || w_brstall) && !w_memstall;
        mem_err  = r_err;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (w_memop && !dmem_ack) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (!w_memop || dmem_ack) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] r_stall_cycles;
    logic [STAT_W-1:0] r_flush_count;
    logic [STAT_W-1:0] r_memwait_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles   <= '0;
            r_flush_count    <= '0;
            r_memwait_cycles <= '0;
        end else begin
            if (stallf && r_stall_cycles != '1) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (flushe && r_flush_count != '1) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
            if (w_memstall && r_memwait_cycles != '1) begin
                r_memwait_cycles <= r_memwait_cycles + 1'b1;
            end
        end
    end

    always_comb begin
        stall_cycles   = r_stall_cycles;
        flush_count    = r_flush_count;
        memwait_cycles = r_memwait_cycles;
    end
`endif

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumes the pipeline controller's hazard-side outputs and returns pipeline steering to the datapath.
  - Inputs from the controller: branchd, regwritee, memtorege, regwritem, memtoregm, regwritew, memwritem.
  - Outputs to the datapath: stall, flush and forwarding selects.
- Covers the classic 5-stage MIPS hazards: forwarding, load-use stall and branch-compare stall.
- Adds a registered memory-wait FSM. It freezes the whole pipeline while a multi-cycle data-memory access is outstanding, with timeout and error capture.

Parameters:
- MEM_TIMEOUT, 16: max cycles spent in WAIT before forced release (2..255).
- STAT_W, 32: width of the optional statistics counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- rsd, rtd  in  5  source register numbers in D
- rse, rte  in  5  source register numbers in E
- writerege, writeregm, writeregw  in  5  destination register in E/M/W
- branchd, regwritee, memtorege, regwritem, memtoregm, memwritem, regwritew  in  1  controller stage-control bits
- dmem_ack  in  1  data memory completes access this cycle
- dmem_req  out  1  data memory access request
- forwardad, forwardbd  out  1  D-stage compare forward from M
- forwardae, forwardbe  out  2  E-stage ALU operand select: 00 regfile, 01 W result, 10 M ALU out
- stallf, stalld, stalle, stallm, stallw  out  1  stage register hold enables (active-high)
- flushe  out  1  clear D/E register (bubble insert)
- mem_err  out  1  sticky memory-timeout flag

Behaviour:
- Forwarding (combinational); register 0 is never forwarded:
  - forwardae = 10 if rse!=0 & rse==writeregm & regwritem.
  - Else forwardae = 01 if rse!=0 & rse==writeregw & regwritew.
  - Else forwardae = 00. M has priority over W.
  - forwardbe: same rule using rte.
  - forwardad = rsd!=0 & rsd==writeregm & regwritem.
  - forwardbd: same rule using rtd.
- lwstall = memtorege & (rte==rsd | rte==rtd).
- branchstall = branchd & ((regwritee & (writerege==rsd | writerege==rtd)) | (memtoregm & (writeregm==rsd | writeregm==rtd))).
- memop = memtoregm | memwritem.
- memstall = memop & ~dmem_ack & ~timeout_hit. timeout_hit is true only in WAIT with cnt==MEM_TIMEOUT-1.
- dmem_req = memop in both states. It is held high through WAIT and drops when memop drops.
- Stall and flush outputs:
  - stallf = stalld = lwstall | branchstall | memstall.
  - stalle = stallm = stallw = memstall.
  - flushe = (lwstall | branchstall) & ~memstall. E is never flushed while frozen.
- FSM states: IDLE, WAIT.
  - IDLE -> WAIT when memop & ~dmem_ack; cnt <= 0.
  - IDLE with memop & dmem_ack: stay in IDLE, zero stall cycles.
  - WAIT with dmem_ack: go to IDLE. Stalls deassert in the ack cycle (combinational), so the pipeline advances on that edge.
  - WAIT with ~dmem_ack & ~timeout_hit: cnt <= cnt+1.
  - WAIT with timeout_hit & ~dmem_ack: go to IDLE, mem_err <= 1, stalls release this cycle.
  - WAIT with memop dropped (must not happen): go to IDLE, no error.
  - Simultaneous ack and timeout_hit: ack wins, mem_err unchanged.
  - After an error release, a subsequent memop restarts from IDLE normally.
- Counter: ceil(log2(MEM_TIMEOUT)) bits; it never wraps in WAIT.
- mem_err: sticky; cleared only by reset.
- Reset (asynchronous, any time, including mid-WAIT):
  - State IDLE, cnt 0, mem_err 0.
  - Combinational outputs follow the inputs immediately; all stall outputs are 0 if there is no hazard.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stall_cycles [STAT_W], flush_count [STAT_W], memwait_cycles [STAT_W].
  - stall_cycles increments every cycle stallf=1.
  - flush_count increments every cycle flushe=1.
  - memwait_cycles increments every cycle memstall=1.
  - Counters saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. rse=5, writeregm=5, regwritem=1, writeregw=5, regwritew=1 -> forwardae=10. Drop regwritem -> forwardae=01. rse=0 with all else matching -> forwardae=00.
2. memtorege=1, rte=8, rsd=8 -> stallf=stalld=1, flushe=1, stalle=0. Next cycle memtorege=0 -> all clear.
3. branchd=1, regwritee=1, writerege=rtd=3 -> stallf=stalld=flushe=1. Then memtoregm=1, writeregm=3, regwritee=0 -> still stalled. forwardbd=1 once regwritem=1 and writeregm=3 with no load pending.
4. memtoregm=1, dmem_ack low 3 cycles then high -> dmem_req=1 throughout, all five stalls=1 for exactly 3 cycles, released in the ack cycle, mem_err=0.
5. MEM_TIMEOUT=4, memwritem=1, dmem_ack never -> stalls high 4 cycles (1 IDLE + 3 WAIT) then released, mem_err=1 and stays 1. Assert reset mid-WAIT in a rerun -> IDLE, mem_err=0 immediately.
6. lwstall plus memstall together -> flushe=0, stalle=1. With HAZARD_STATS_EN, over 10 cycles of scenario 4 the counters match stall/flush/memwait cycle counts exactly.
